// File: rtl/sig_pkg.sv
// Shared lamp codes, phase encodings and default timing for the intersection scheduler.
package sig_pkg;

    typedef enum logic [1:0] {
        PhAllred = 2'd0,
        PhGreen  = 2'd1,
        PhYellow = 2'd2
    } phase_e;

    localparam logic [1:0] LampRed    = 2'd0;
    localparam logic [1:0] LampYellow = 2'd1;
    localparam logic [1:0] LampGreen  = 2'd2;

    localparam int unsigned DefNAppr      = 4;
    localparam int unsigned DefCw         = 4;
    localparam int unsigned DefMinGreen   = 5;
    localparam int unsigned DefMaxGreen   = 12;
    localparam int unsigned DefYelTime    = 3;
    localparam int unsigned DefAllredTime = 2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after i_cur, wrapping, with i_cur itself last.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_cur,
    output logic [IW-1:0] o_next,
    output logic          o_any
);

    logic [IW-1:0] w_idx;

    // Scan farthest-first so the nearest requester after i_cur is written last and wins.
    always_comb begin
        o_next = '0;
        o_any  = 1'b0;
        w_idx  = '0;
        for (int k = int'(N); k >= 1; k--) begin
            w_idx = IW'((int'(i_cur) + k) % int'(N));
            if (i_req[w_idx]) begin
                o_next = w_idx;
                o_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sig_sched.sv
// Round-robin GREEN/YELLOW/ALL-RED phase scheduler for N approaches.
// Optional emergency preemption is enabled by defining SIG_EMERG_PREEMPT_EN.
module sig_sched
    import sig_pkg::*;
#(
    parameter int unsigned N_APPR      = DefNAppr,
    parameter int unsigned CW          = DefCw,
    parameter int unsigned MIN_GREEN   = DefMinGreen,
    parameter int unsigned MAX_GREEN   = DefMaxGreen,
    parameter int unsigned YEL_TIME    = DefYelTime,
    parameter int unsigned ALLRED_TIME = DefAllredTime,
    localparam int unsigned IW         = idx_width(N_APPR)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [N_APPR-1:0]     req,
`ifdef SIG_EMERG_PREEMPT_EN
    input  logic                  emerg,
    input  logic [IW-1:0]         emerg_id,
`endif
    output logic [2*N_APPR-1:0]   sig,
    output logic [N_APPR-1:0]     grant,
    output logic [1:0]            phase
);

    localparam logic [CW-1:0] MinGreenLast = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MaxGreenLast = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YelLast      = CW'(YEL_TIME - 1);
    localparam logic [CW-1:0] AllredLast   = CW'(ALLRED_TIME - 1);
    localparam logic [CW-1:0] TimerMax     = '1;

    phase_e             r_phase;
    logic [IW-1:0]      r_cur;
    logic [CW-1:0]      r_timer;

    logic [N_APPR-1:0]  w_cur_oh;
    logic               w_other;
    logic               w_green_done;
    logic               w_leave_green;
    logic [IW-1:0]      w_rr_next;
    logic               w_rr_any;
    logic [IW-1:0]      w_next_cur;

    rr_pick #(
        .N  (N_APPR),
        .IW (IW)
    ) u_rr_pick (
        .i_req  (req),
        .i_cur  (r_cur),
        .o_next (w_rr_next),
        .o_any  (w_rr_any)
    );

    assign w_cur_oh = {{(N_APPR-1){1'b0}}, 1'b1} << r_cur;
    assign w_other  = |(req & ~w_cur_oh);

    // Green ends only when someone else waits: early once the owner leaves, else at the cap.
    assign w_green_done = w_other &&
                          (((r_timer >= MinGreenLast) && !req[r_cur]) ||
                           (r_timer >= MaxGreenLast));

`ifdef SIG_EMERG_PREEMPT_EN
    assign w_leave_green = (emerg && (emerg_id != r_cur)) ||
                           (!(emerg && (emerg_id == r_cur)) && w_green_done);
    assign w_next_cur    = emerg ? emerg_id : (w_rr_any ? w_rr_next : '0);
`else
    assign w_leave_green = w_green_done;
    assign w_next_cur    = w_rr_any ? w_rr_next : '0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            r_phase <= PhAllred;
            r_cur   <= '0;
            r_timer <= '0;
        end else begin
            r_timer <= (r_timer == TimerMax) ? r_timer : r_timer + 1'b1;
            case (r_phase)
                PhAllred: begin
                    if (r_timer == AllredLast) begin
                        r_phase <= PhGreen;
                        r_cur   <= w_next_cur;
                        r_timer <= '0;
                    end
                end
                PhGreen: begin
                    if (w_leave_green) begin
                        r_phase <= PhYellow;
                        r_timer <= '0;
                    end
                end
                PhYellow: begin
                    if (r_timer == YelLast) begin
                        r_phase <= PhAllred;
                        r_timer <= '0;
                    end
                end
                default: begin
                    r_phase <= PhAllred;
                    r_timer <= '0;
                end
            endcase
        end
    end

    always_comb begin
        sig   = '0;
        grant = '0;
        for (int i = 0; i < int'(N_APPR); i++) begin
            if (IW'(i) == r_cur) begin
                if (r_phase == PhGreen) begin
                    sig[2*i +: 2] = LampGreen;
                    grant[i]      = 1'b1;
                end else if (r_phase == PhYellow) begin
                    sig[2*i +: 2] = LampYellow;
                    grant[i]      = 1'b1;
                end
            end
        end
    end

    assign phase = r_phase;

endmodule

// File: tb/tb_sig_sched.sv
// Scoreboard bench for sig_sched: stimulus queues per-cycle expected lamps, a monitor checks them.
module tb_sig_sched;

    logic       clock;
    logic       clear;
    logic [3:0] req;
    logic [7:0] sig;
    logic [3:0] grant;
    logic [1:0] phase;
`ifdef SIG_EMERG_PREEMPT_EN
    logic       emerg;
    logic [1:0] emerg_id;
`endif

    sig_sched u_dut (
        .clock    (clock),
        .clear    (clear),
        .req      (req),
`ifdef SIG_EMERG_PREEMPT_EN
        .emerg    (emerg),
        .emerg_id (emerg_id),
`endif
        .sig      (sig),
        .grant    (grant),
        .phase    (phase)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int unsigned cyc;
        logic [1:0]  ph;
        logic [3:0]  gr;
        logic [7:0]  sg;
    } exp_t;

    localparam logic [1:0] AR = 2'd0;
    localparam logic [1:0] GR = 2'd1;
    localparam logic [1:0] YE = 2'd2;

    exp_t        q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc_n = 0;

    // Expected lamps for one phase segment: owner lit GREEN (2) or YELLOW (1), others RED.
    task automatic push_seg(input int unsigned start, input int unsigned len,
                            input logic [1:0] ph, input int owner);
        exp_t e;
        for (int j = 0; j < int'(len); j++) begin
            e.cyc = start + j;
            e.ph  = ph;
            e.gr  = (ph == AR) ? 4'b0000 : (4'b0001 << owner);
            e.sg  = (ph == GR) ? (8'h02 << (2 * owner)) :
                    (ph == YE) ? (8'h01 << (2 * owner)) : 8'h00;
            q.push_back(e);
        end
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc_n < c) begin
            @(negedge clock);
            #1;
        end
    endtask

    // Monitor: every falling edge, check any expectation due this cycle plus the one-lit invariant.
    initial begin
        exp_t e;
        int   nonred;
        forever begin
            @(negedge clock);
            cyc_n++;
            while (q.size() > 0 && q[0].cyc < cyc_n) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL stale cyc=%0d expectation for cyc %0d never checked", cyc_n, e.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc_n) begin
                e = q.pop_front();
                total++;
                if (phase !== e.ph || grant !== e.gr || sig !== e.sg) begin
                    bad++;
                    $display("FAIL lamps cyc=%0d got ph=%0d grant=%b sig=%h want ph=%0d grant=%b sig=%h",
                             cyc_n, phase, grant, sig, e.ph, e.gr, e.sg);
                end
            end
            nonred = 0;
            for (int i = 0; i < 4; i++) begin
                if (sig[2*i +: 2] !== 2'b00) nonred++;
            end
            total++;
            if (nonred > 1) begin
                bad++;
                $display("FAIL one_lit cyc=%0d got %0d non-red fields want <=1 (sig=%h)",
                         cyc_n, nonred, sig);
            end
        end
    end

    initial begin
        int unsigned b, g, h, k, m, s;
`ifdef SIG_EMERG_PREEMPT_EN
        int unsigned e;
        emerg    = 1'b0;
        emerg_id = 2'd0;
`endif
        clear = 1'b1;
        req   = 4'b0000;
        @(negedge clock);
        #1;

        // Reset release, idle: ALLRED 2 cycles, then home approach 0 green indefinitely.
        b = cyc_n;
        push_seg(b + 1, 2, AR, 0);
        push_seg(b + 3, 55, GR, 0);
        wait_until(b + 1);
        clear = 1'b0;

        // One-cycle request from 2 forces yellow but is forgotten by ALLRED exit.
        g = b + 58;
        wait_until(g);
        req = 4'b0100;
        push_seg(g + 1, 3, YE, 0);
        push_seg(g + 4, 2, AR, 0);
        push_seg(g + 6, 10, GR, 0);
        wait_until(g + 1);
        req = 4'b0000;

        // Held request from 2: handover, then 2 holds alone.
        h = g + 16;
        wait_until(h);
        req = 4'b0100;
        push_seg(h + 1, 3, YE, 0);
        push_seg(h + 4, 2, AR, 0);
        push_seg(h + 6, 20, GR, 2);

        // Everyone requesting: 12-cycle greens in order 3,0,1,2, 17-cycle period.
        k = h + 26;
        wait_until(k);
        req = 4'b1111;
        push_seg(k + 1, 3, YE, 2);
        push_seg(k + 4, 2, AR, 2);
        s = k + 6;
        for (int o = 3; o <= 5; o++) begin
            push_seg(s, 12, GR, o % 4);
            push_seg(s + 12, 3, YE, o % 4);
            push_seg(s + 15, 2, AR, o % 4);
            s = s + 17;
        end
        push_seg(s, 12, GR, 2);
        push_seg(s + 12, 1, YE, 2);

        // Clear during approach 2 yellow: immediate ALLRED, then arbitration from cur=0.
        wait_until(s + 12);
        clear = 1'b1;
        push_seg(s + 13, 2, AR, 0);
        push_seg(s + 15, 12, GR, 1);
        push_seg(s + 27, 3, YE, 1);
        push_seg(s + 30, 2, AR, 1);
        push_seg(s + 32, 5, GR, 2);
        wait_until(s + 13);
        clear = 1'b0;

        // Two requesters 0 and 1 alternate at max green; then owner drop ends green at min.
        m = s + 37;
        wait_until(m);
        clear = 1'b1;
        req   = 4'b0000;
        push_seg(m + 1, 2, AR, 0);
        push_seg(m + 3, 12, GR, 0);
        push_seg(m + 15, 3, YE, 0);
        push_seg(m + 18, 2, AR, 0);
        push_seg(m + 20, 12, GR, 1);
        push_seg(m + 32, 3, YE, 1);
        push_seg(m + 35, 2, AR, 1);
        push_seg(m + 37, 5, GR, 0);
        push_seg(m + 42, 3, YE, 0);
        push_seg(m + 45, 2, AR, 0);
        push_seg(m + 47, 10, GR, 1);
        wait_until(m + 1);
        clear = 1'b0;
        wait_until(m + 3);
        req = 4'b0011;
        wait_until(m + 37);
        req = 4'b0010;
        wait_until(m + 57);

`ifdef SIG_EMERG_PREEMPT_EN
        // Emergency for 3 preempts a 1-cycle green and overrides round-robin at ALLRED exit.
        e = cyc_n;
        clear = 1'b1;
        req   = 4'b0000;
        push_seg(e + 1, 2, AR, 0);
        push_seg(e + 3, 1, GR, 0);
        push_seg(e + 4, 3, YE, 0);
        push_seg(e + 7, 2, AR, 0);
        push_seg(e + 9, 16, GR, 3);
        push_seg(e + 25, 3, YE, 3);
        push_seg(e + 28, 2, AR, 3);
        push_seg(e + 30, 3, GR, 1);
        wait_until(e + 1);
        clear = 1'b0;
        wait_until(e + 3);
        req      = 4'b0110;
        emerg    = 1'b1;
        emerg_id = 2'd3;
        wait_until(e + 24);
        emerg = 1'b0;
        wait_until(e + 33);
`endif

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clock);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending expectations want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
